// File: rtl/vec_prefetch_buf.sv
// Dense-vector prefetch buffer: fetches a contiguous vector as whole lines, takes responses out of order, and serves NUM_CH combinational readers.
// Optional macro VEC_PREFETCH_OOB_CHK_EN adds out-of-bounds read flags (rd_oob) and a sticky error (err_oob).
module vec_prefetch_buf #(
  parameter int DATA_W    = 32,
  parameter int NUM_CH    = 16,
  parameter int DEPTH     = 1024,
  parameter int LINE_W    = 512,
  parameter int ADDR_W    = 40,
  parameter int MAX_OUTST = 8,
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        vec_base,
  input  logic [IDX_W:0]           vec_len,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_req_val,
  input  logic                     mem_req_rdy,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [5:0]               mem_req_transid,
  input  logic                     mem_resp_val,
  input  logic [5:0]               mem_resp_transid,
  input  logic [LINE_W-1:0]        mem_resp_data,
  input  logic [NUM_CH*IDX_W-1:0]  rd_idx,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0]        rd_hit,
`ifdef VEC_PREFETCH_OOB_CHK_EN
  output logic [NUM_CH-1:0]        rd_oob,
  output logic                     err_oob,
`endif
  output logic [1:0]               dbg_state
);

  localparam int EPL   = LINE_W / DATA_W;
  localparam int EPL_B = $clog2(EPL);
  localparam int LINE_B = LINE_W / 8;
  localparam int LB_B  = $clog2(LINE_B);
  localparam int ELB_B = $clog2(DATA_W / 8);
  localparam int LEN_W = IDX_W + 1;
  localparam int LN_W  = IDX_W + 1;
  localparam int POS_W = LN_W + EPL_B + 1;
  localparam int OC_W  = 7;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_DONE} state_t;

  // Request handshake: a request transfers when mem_req_val && mem_req_rdy;
  // addr/transid only change after a transfer, so they hold while stalled.
  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [POS_W-1:0]   off_q, off_d;
  logic [LN_W-1:0]    nlines_q, nlines_d;
  logic [LN_W-1:0]    issued_q, issued_d;
  logic [LN_W-1:0]    recv_q, recv_d;
  logic [OC_W-1:0]    outst_q, outst_d;
  logic [63:0]        tab_v_q, tab_v_d;
  logic [LN_W-1:0]    tab_ln_q [64];
  logic [LN_W-1:0]    tab_ln_d [64];
  logic [DEPTH-1:0]   loaded_q, loaded_d;
  logic [DATA_W-1:0]  vec_mem_q [DEPTH];

  logic [LEN_W-1:0]   len_in;
  logic [POS_W-1:0]   off_in;
  logic [LN_W-1:0]    nl_in;
  logic               req_hs;
  logic               resp_acc;
  logic [LN_W-1:0]    resp_ln;
  logic [EPL-1:0]     wr_en;
  logic [IDX_W-1:0]   wr_idx [EPL];
  logic [DATA_W-1:0]  wr_dat [EPL];

  assign len_in = (vec_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : vec_len;
  assign off_in = POS_W'(vec_base[LB_B-1:0] >> ELB_B);
  assign nl_in  = LN_W'((off_in + POS_W'(len_in) + POS_W'(EPL - 1)) >> EPL_B);

  assign mem_req_val     = (state_q == S_REQ) && (outst_q < OC_W'(MAX_OUTST)) &&
                           (issued_q < nlines_q);
  assign mem_req_addr    = base_q + ADDR_W'(issued_q) * ADDR_W'(LINE_B);
  assign mem_req_transid = issued_q[5:0];
  assign req_hs          = mem_req_val && mem_req_rdy;
  assign resp_acc        = mem_resp_val && tab_v_q[mem_resp_transid];
  assign resp_ln         = tab_ln_q[mem_resp_transid];
  assign busy            = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign dbg_state       = state_q;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    off_d    = off_q;
    nlines_d = nlines_q;
    issued_d = issued_q + LN_W'(req_hs);
    recv_d   = recv_q + LN_W'(resp_acc);
    outst_d  = outst_q;
    if (req_hs && !resp_acc)      outst_d = outst_q + OC_W'(1);
    else if (!req_hs && resp_acc) outst_d = outst_q - OC_W'(1);
    tab_v_d  = tab_v_q;
    tab_ln_d = tab_ln_q;
    if (resp_acc) tab_v_d[mem_resp_transid] = 1'b0;
    if (req_hs) begin
      tab_v_d[issued_q[5:0]]  = 1'b1;
      tab_ln_d[issued_q[5:0]] = issued_q;
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_d   = vec_base & ~ADDR_W'(LINE_B - 1);
          len_d    = len_in;
          off_d    = off_in;
          nlines_d = nl_in;
          issued_d = '0;
          recv_d   = '0;
          outst_d  = '0;
          tab_v_d  = '0;
          state_d  = (len_in == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ:   if (req_hs && issued_d == nlines_q) state_d = S_DRAIN;
      S_DRAIN: if (recv_d == nlines_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Word w of line k is element k*EPL + w - off; only in-range elements land.
  always_comb begin
    wr_en = '0;
    for (int w = 0; w < EPL; w++) begin
      logic [POS_W-1:0] pos;
      pos       = POS_W'(resp_ln) * POS_W'(EPL) + POS_W'(w);
      wr_en[w]  = resp_acc && (pos >= off_q) && ((pos - off_q) < POS_W'(len_q));
      wr_idx[w] = IDX_W'(pos - off_q);
      wr_dat[w] = mem_resp_data[w*DATA_W +: DATA_W];
    end
    loaded_d = loaded_q;
    if ((state_q == S_IDLE || state_q == S_DONE) && start) loaded_d = '0;
    for (int w = 0; w < EPL; w++) begin
      if (wr_en[w]) loaded_d[wr_idx[w]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      off_q    <= '0;
      nlines_q <= '0;
      issued_q <= '0;
      recv_q   <= '0;
      outst_q  <= '0;
      tab_v_q  <= '0;
      loaded_q <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      off_q    <= off_d;
      nlines_q <= nlines_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      outst_q  <= outst_d;
      tab_v_q  <= tab_v_d;
      loaded_q <= loaded_d;
    end
  end

  // Line numbers and element storage are qualified by valid/loaded bits.
  always_ff @(posedge clk) begin
    tab_ln_q <= tab_ln_d;
    for (int w = 0; w < EPL; w++) begin
      if (wr_en[w]) vec_mem_q[wr_idx[w]] <= wr_dat[w];
    end
  end

`ifdef VEC_PREFETCH_OOB_CHK_EN
  logic err_oob_q, err_oob_d;

  always_comb begin
    rd_data = '0;
    rd_hit  = '0;
    rd_oob  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [IDX_W-1:0] ridx;
      ridx      = rd_idx[c*IDX_W +: IDX_W];
      rd_oob[c] = ({1'b0, ridx} >= len_q);
      rd_hit[c] = loaded_q[ridx] || rd_oob[c];
      if (loaded_q[ridx] && !rd_oob[c]) rd_data[c*DATA_W +: DATA_W] = vec_mem_q[ridx];
    end
    err_oob_d = err_oob_q || (|rd_oob);
    if ((state_q == S_IDLE || state_q == S_DONE) && start) err_oob_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_oob_q <= 1'b0;
    else        err_oob_q <= err_oob_d;
  end

  assign err_oob = err_oob_q;
`else
  always_comb begin
    rd_data = '0;
    rd_hit  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [IDX_W-1:0] ridx;
      ridx      = rd_idx[c*IDX_W +: IDX_W];
      rd_hit[c] = loaded_q[ridx];
      if (loaded_q[ridx]) rd_data[c*DATA_W +: DATA_W] = vec_mem_q[ridx];
    end
  end
`endif

endmodule

// File: doc/vec_prefetch_buf.md
Name: vec_prefetch_buf

Overview:
Parametrised dense-vector prefetch buffer for the SpMV datapath. On start it fetches a contiguous vector of DATA_W elements from memory as full cache lines, with a bounded number of requests in flight. Responses may arrive out of order and are steered by transaction ID. NUM_CH channels read elements combinationally by column index, with a per-element hit flag, so channels can consume values before the whole prefetch completes.

Parameters:
DATA_W, 32, element width in bits
NUM_CH, 16, number of read channels
DEPTH, 1024, buffer capacity in elements (power of 2); IDX_W = clog2(DEPTH)
LINE_W, 512, memory response line width in bits; EPL = LINE_W/DATA_W elements per line (power of 2)
ADDR_W, 40, physical address width
MAX_OUTST, 8, max outstanding requests (1..64)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a prefetch; honoured only in IDLE or DONE
vec_base  in  ADDR_W  byte address of element 0, DATA_W/8 aligned
vec_len  in  IDX_W+1  element count
busy  out  1  state is REQ or DRAIN
done  out  1  prefetch complete; held until next start or reset
mem_req_val  out  1  request valid
mem_req_rdy  in  1  request ready
mem_req_addr  out  ADDR_W  line-aligned request address
mem_req_transid  out  6  transaction ID
mem_resp_val  in  1  response valid, no backpressure
mem_resp_transid  in  6  response ID
mem_resp_data  in  LINE_W  line data, element w at bits [w*DATA_W +: DATA_W]
rd_idx  in  NUM_CH x IDX_W  per-channel element index
rd_data  out  NUM_CH x DATA_W  element value, 0 if not loaded
rd_hit  out  NUM_CH  element loaded

Behaviour:
- Reset: state IDLE; busy, done and mem_req_val at 0; all loaded bits, counters and the outstanding table cleared. Responses arriving after reset are dropped.
- start in IDLE/DONE: latch base and len_eff = min(vec_len, DEPTH); off = element offset within line = (vec_base mod LINE_W/8)/(DATA_W/8); nlines = ceil((off+len_eff)/EPL); clear all loaded bits and done; go to REQ. If len_eff = 0, go to DONE directly: done = 1 on the next cycle, no requests issued. start while busy is ignored.
- REQ: mem_req_val = 1 when outstanding < MAX_OUTST and issued < nlines. Address = line-aligned base + issued*(LINE_W/8). Transid = issued[5:0]. The outstanding table entry [transid] records the line number and a valid bit. Handshake = val&&rdy; addr and transid must stay stable while val=1 and rdy=0. When the final line is issued, go to DRAIN.
- Response: if mem_resp_val and the table entry for mem_resp_transid is valid, take line k from the table and clear the entry. For each w in 0..EPL-1, idx = k*EPL + w - off; when 0 <= idx < len_eff, write the element and set loaded[idx]. Any other response (not outstanding) is dropped without side effects.
- The outstanding count is updated on every cycle: +1 on a request handshake, -1 on an accepted response. A handshake and a response in the same cycle leave the count unchanged. A response may return the ID being issued in the same cycle only on a later cycle.
- DRAIN: done once received == nlines, with done = 1 the cycle after the last response write. Before that, mem_req_val = 0.
- Reads are combinational: rd_data[c] = loaded ? buf[rd_idx[c]] : 0, and rd_hit[c] = loaded. A write is visible the cycle after the response.
- Address arithmetic is ADDR_W wide with no wrap check; the caller guarantees the range.

Optional Feature:
VEC_PREFETCH_OOB_CHK_EN:
- Defined: adds the output rd_oob (NUM_CH bits) and the output err_oob (1 bit, sticky). When rd_idx[c] >= len_eff: rd_data = 0, rd_hit = 1, rd_oob[c] = 1, and err_oob is set next cycle. err_oob clears on start or reset.
- Undefined: no extra ports. An out-of-range index reads as not loaded (rd_hit = 0, rd_data = 0).

Test Plan:
- Aligned fetch, base=0x1000, len=32, rdy=1, in-order responses -> requests 0x1000 (id 0) and 0x1040 (id 1); done at cycle after 2nd response; rd_idx=17 returns word 1 of line 1.
- Unaligned fetch, base=0x1008, len=20 -> off=2, nlines=2; element 0 = word 2 of line 0, element 19 = word 5 of line 1; words 6..15 of line 1 not written.
- Flow control, len=256 (16 lines), MAX_OUTST=8, responses withheld -> exactly 8 handshakes, then mem_req_val=0; one response returned -> exactly one more request issued.
- Out-of-order responses for ids 3,0,2,1 -> each line lands at the correct index; rd_hit sets per line as it lands; done only after all 4 lines.
- Backpressure: rdy=0 for 5 cycles -> addr and transid stable; len=0 -> done next cycle, no requests; start while busy ignored.
- Reset mid-DRAIN, then a stale response id 2 -> dropped, loaded bits stay 0. With OOB_CHK_EN, rd_idx=len -> rd_oob=1, rd_hit=1, err_oob set.
